// File: rtl/nn_pkg.sv
// nn_pkg: shared sizing constants and FSM state type for the nn datapath blocks
package nn_pkg;
  localparam int DEF_MATRIX_SIZE = 16;
  localparam int DEF_DATA_SIZE = 8;
  localparam int SHIFT_W = 3;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/relu_requant_lane.sv
// relu_requant_lane: combinational ReLU, round-half-up right shift and clamp for one element
module relu_requant_lane
  import nn_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic [DATA_SIZE-1:0] x,
  input  logic [SHIFT_W-1:0]   s,
  output logic [DATA_SIZE-1:0] y
);
  localparam int W = DATA_SIZE;
  localparam logic [W:0] MAXV = (W+1)'((1 << (W-1)) - 1);
  logic [W:0] r, rnd, q;
  // one extra bit of headroom so the rounding add cannot wrap
  always_comb begin
    r = x[W-1] ? '0 : {1'b0, x};
    rnd = (s == '0) ? '0 : ((W+1)'(1) << (s - SHIFT_W'(1)));
    q = (r + rnd) >> s;
    y = (q > MAXV) ? MAXV[W-1:0] : q[W-1:0];
  end
endmodule

// File: rtl/act_requant.sv
// act_requant: row-serial ReLU + requantization of an NxN matrix with per-row maximum
module act_requant
  import nn_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [DATA_SIZE-1:0] in_matrix [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] out_matrix [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  output logic [DATA_SIZE-1:0] row_max [0:MATRIX_SIZE-1]
);
  localparam int N = MATRIX_SIZE;
  localparam int W = DATA_SIZE;
  localparam int RW = N > 1 ? $clog2(N) : 1;
  state_t state;
  logic [RW-1:0] row;
  logic [SHIFT_W-1:0] shift_q;
  logic [W-1:0] mat_q [0:N-1][0:N-1];
  logic [W-1:0] y [0:N-1];
  logic [W-1:0] mx;
  for (genvar i = 0; i < N; i++) begin : g_lane
    relu_requant_lane #(.DATA_SIZE(W)) u_lane (
      .x(mat_q[row][i]),
      .s(shift_q),
      .y(y[i])
    );
  end
  always_comb begin
    mx = '0;
    for (int j = 0; j < N; j++) mx = (y[j] > mx) ? y[j] : mx;
  end
  // the input is snapshotted on accept so the producer may move on immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      row <= '0;
      shift_q <= '0;
      mat_q <= '{default: '0};
      out_matrix <= '{default: '0};
      row_max <= '{default: '0};
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          mat_q <= in_matrix;
          shift_q <= shift;
          row <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
      end else begin
        out_matrix[row] <= y;
        row_max[row] <= mx;
        row <= row + RW'(1);
        if (row == RW'(N - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_act_requant.sv
// tb_act_requant: table vectors plus handshake/reset sequences, scoreboarded per matrix
module tb_act_requant;
  localparam int N = 16;
  localparam int W = 8;
  typedef logic [0:N-1][0:N-1][W-1:0] mat_t;
  typedef struct {
    logic [W-1:0] x;
    int s;
    logic [W-1:0] y;
  } vec_t;
  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic [2:0] shift;
  logic [W-1:0] in_matrix [0:N-1][0:N-1];
  logic [W-1:0] out_matrix [0:N-1][0:N-1];
  logic [W-1:0] row_max [0:N-1];
  mat_t q[$];
  int checks = 0;
  int errors = 0;
  vec_t tv [11];

  always #5 clk = ~clk;

  act_requant #(.MATRIX_SIZE(N), .DATA_SIZE(W)) dut (
    .clk(clk), .reset(reset), .start(start), .shift(shift), .in_matrix(in_matrix),
    .busy(busy), .done(done), .out_matrix(out_matrix), .row_max(row_max)
  );

  function automatic logic [W-1:0] ref_y(logic [W-1:0] x, int s);
    int r, v;
    r = x[W-1] ? 0 : int'(x);
    v = (s == 0) ? r : (r + (1 << (s - 1))) >> s;
    return (v > 127) ? 8'd127 : W'(v);
  endfunction

  function automatic mat_t model(mat_t m, int s);
    mat_t e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[i][j] = ref_y(m[i][j], s);
    return e;
  endfunction

  function automatic mat_t fill(logic [W-1:0] x);
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = x;
    return m;
  endfunction

  function automatic mat_t rnd_m();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = W'($urandom);
    return m;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(mat_t m, int s);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) in_matrix[i][j] = m[i][j];
    shift = 3'(s);
  endtask

  task automatic launch(mat_t m, int s);
    drive(m, s);
    start = 1'b1;
    q.push_back(model(m, s));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sb_check(string nm);
    mat_t e;
    int a, x, mm;
    bit f;
    chk({nm, "_sb"}, int'(q.size() > 0), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      a = 0; x = 0; f = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (!f && out_matrix[i][j] !== e[i][j]) begin
            a = int'(out_matrix[i][j]); x = int'(e[i][j]); f = 1;
          end
      chk({nm, "_mat"}, a, x);
      a = 0; x = 0; f = 0;
      for (int i = 0; i < N; i++) begin
        mm = 0;
        for (int j = 0; j < N; j++) if (int'(e[i][j]) > mm) mm = int'(e[i][j]);
        if (!f && int'(row_max[i]) != mm) begin
          a = int'(row_max[i]); x = mm; f = 1;
        end
      end
      chk({nm, "_rowmax"}, a, x);
    end
  endtask

  task automatic finish_check(string nm);
    int n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, N + 1);
    chk({nm, "_busy_low"}, busy, 0);
    sb_check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t m;
    int pm [0:N-1];
    int nz, seen;
    tv = '{'{8'hFB, 0, 8'h00}, '{8'h7F, 1, 8'h40}, '{8'h03, 1, 8'h02}, '{8'h02, 1, 8'h01},
           '{8'h80, 1, 8'h00}, '{8'h45, 0, 8'h45}, '{8'h7F, 7, 8'h01}, '{8'h3F, 7, 8'h00},
           '{8'h0C, 3, 8'h02}, '{8'h0B, 3, 8'h01}, '{8'h7F, 0, 8'h7F}};
    reset = 1'b1;
    drive(fill(8'h7F), 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out_matrix[3][4], 0);
    chk("rst_rowmax", row_max[7], 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int k = 0; k < 11; k++) begin
      launch(fill(tv[k].x), tv[k].s);
      chk($sformatf("vec%0d_busy", k), busy, 1);
      finish_check($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_y", k), out_matrix[5][9], tv[k].y);
      chk($sformatf("vec%0d_max", k), row_max[N-1], tv[k].y);
    end

    for (int i = 0; i < N; i++) begin
      pm[i] = int'(row_max[i]);
      for (int j = 0; j < N; j++) m[i][j] = W'(i + j);
    end
    launch(m, 2);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk($sformatf("rm_row%0d", k), row_max[k], (k + 17) >> 2);
      if (k < N - 1) chk($sformatf("rm_keep%0d", k + 1), row_max[k + 1], pm[k + 1]);
    end
    chk("rm_done", done, 1);
    sb_check("rowmax");

    launch(rnd_m(), 1);
    drive(rnd_m(), 3);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_busy_e5", busy, 1);
    chk("hs_done_e5", done, 0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_done_e16", done, 1);
    chk("hs_busy_e16", busy, 0);
    sb_check("hs");
    launch(rnd_m(), 2);
    chk("hs_busy_e17", busy, 1);
    finish_check("hs2");

    launch(rnd_m(), 1);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    nz = 0;
    for (int i = 0; i < N; i++) begin
      if (row_max[i] != 0) nz++;
      for (int j = 0; j < N; j++) if (out_matrix[i][j] != 0) nz++;
    end
    chk("rmid_clear", nz, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    void'(q.pop_front());
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(done);
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(done);
    end
    chk("rmid_nodone", seen, 0);
    launch(rnd_m(), 0);
    finish_check("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
